// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Brief    : Shared memory-op codes, access FSM states and timeout default.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_SW   = 3'b001;
    localparam logic [2:0] MEM_SB   = 3'b011;
    localparam logic [2:0] MEM_LB   = 3'b010;
    localparam logic [2:0] MEM_LBU  = 3'b110;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Word-addressed memory request/response bus.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Selects and extends load data from a returned memory word.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0] w_byte;

    always_comb begin
        w_byte = rdata[7:0];
        case (byte_off)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
    end

    // A latched op of MEM_NONE can only be a word load; stores return zero.
    always_comb begin
        data = '0;
        case (op)
            MEM_NONE: data = rdata;
            MEM_LB:   data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU:  data = {24'd0, w_byte};
            default:  data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : M-stage load/store sequencer with alignment check and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        FaultM,
    mem_access_unit_if.master bus
);

    localparam logic [3:0] C_TIMEOUT = 4'(TIMEOUT);

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  op_q, op_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        w_is_lw;
    logic        w_op_valid;
    logic        w_misaligned;
    logic [31:0] w_load_data;

    assign w_is_lw    = (MemWriteM == MEM_NONE) && (ResultSrcM == RES_LOAD);
    assign w_op_valid = (MemWriteM == MEM_SW) || (MemWriteM == MEM_SB) ||
                        (MemWriteM == MEM_LB) || (MemWriteM == MEM_LBU) || w_is_lw;
    assign w_misaligned = ((MemWriteM == MEM_SW) || w_is_lw) && (ALUResultM[1:0] != 2'b00);

    load_align u_load_align (
        .op       (op_q),
        .byte_off (off_q),
        .rdata    (bus.mem_rdata),
        .data     (w_load_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        op_d    = op_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        cnt_d   = cnt_q;
        StallM  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_op_valid) begin
                    StallM = 1'b1;
                    if (w_misaligned) begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        addr_d  = ALUResultM[31:2];
                        off_d   = ALUResultM[1:0];
                        op_d    = MemWriteM;
                        case (MemWriteM)
                            MEM_SW: begin
                                we_d    = 1'b1;
                                be_d    = 4'b1111;
                                wdata_d = WriteDataM;
                            end
                            MEM_SB: begin
                                we_d    = 1'b1;
                                be_d    = 4'b0001 << ALUResultM[1:0];
                                wdata_d = {4{WriteDataM[7:0]}};
                            end
                            default: begin
                                we_d    = 1'b0;
                                be_d    = 4'b1111;
                                wdata_d = '0;
                            end
                        endcase
                    end
                end
            end
            ST_BUSY: begin
                StallM = 1'b1;
                // Ack is checked first so it wins over a simultaneous timeout.
                if (bus.mem_ack) begin
                    state_d = ST_DONE;
                    rdata_d = w_load_data;
                end else if (cnt_q == C_TIMEOUT) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            op_q    <= op_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request decoded straight from the state flop so reset drops it at once.
    assign bus.mem_req   = (state_q == ST_BUSY);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign ReadDataM     = rdata_q;
    assign FaultM        = fault_q;

endmodule
`default_nettype wire
